forward_grant_module: RTL and testbench



---
 rtl/forward_grant_pkg.sv | 35 +++
 rtl/forward_grant_module_rr_arbiter.sv | 49 ++++
 rtl/forward_grant_module.sv | 193 +++++++++++++++++++
 tb/tb_forward_grant_module.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_grant_pkg.sv
// forward_grant_pkg
// Shared definitions for the forward grant responder: FSM state encoding,
// the upper bound on requester count, the grant index width, the default
// per-slot byte budget and the round-robin wrap helper used by rr_arbiter.
package forward_grant_pkg;

  localparam int MAX_PORTS  = 8;
  localparam int GRANT_ID_W = 3;

  // One maximum-size Ethernet frame; a sensible budget when the scheduler
  // has nothing better to offer.
  localparam logic [31:0] DEFAULT_BUDGET = 32'd1518;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GRANT    = 3'd1;
  localparam logic [2:0] ST_BUDGET   = 3'd2;
  localparam logic [2:0] ST_GUARD    = 3'd3;
  localparam logic [2:0] ST_WAIT_FIN = 3'd4;

  // Port index `step` positions after `base`, modulo `ports`.
  // base < ports and step <= ports, so one subtraction is enough.
  function automatic logic [GRANT_ID_W-1:0] rr_wrap(
    input logic [GRANT_ID_W-1:0] base,
    input int                    step,
    input int                    ports
  );
    int sum;
    sum = int'(base) + step;
    if (sum >= ports) begin
      sum = sum - ports;
    end
    return GRANT_ID_W'(sum);
  endfunction

endpackage

// File: rtl/forward_grant_module_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick. Scans the request vector starting
// one position after `last`, wrapping, and reports the first requester.
// Ports:
//   req      in  P_PORTS     request vector
//   last     in  3           index of the previously served port
//   grant    out P_PORTS     one-hot winner (all zero when no request)
//   grant_id out 3           index of the winner (0 when no request)
//   valid    out 1           at least one request present
module rr_arbiter
  import forward_grant_pkg::*;
#(
  parameter int P_PORTS = 4
) (
  input  logic [P_PORTS-1:0]    req,
  input  logic [GRANT_ID_W-1:0] last,
  output logic [P_PORTS-1:0]    grant,
  output logic [GRANT_ID_W-1:0] grant_id,
  output logic                  valid
);

  // Widened so that a 3-bit index can address it for any port count.
  logic [MAX_PORTS-1:0]  req_ext;
  logic [GRANT_ID_W-1:0] cand [P_PORTS];

  assign req_ext = MAX_PORTS'(req);

  // cand[k] is the port examined at priority rank k (rank 0 = highest).
  for (genvar gi = 0; gi < P_PORTS; gi++) begin : g_cand
    assign cand[gi] = rr_wrap(last, gi + 1, P_PORTS);
  end

  always_comb begin
    valid    = 1'b0;
    grant_id = '0;
    grant    = '0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int i = P_PORTS - 1; i >= 0; i--) begin
      if (req_ext[cand[i]]) begin
        valid    = 1'b1;
        grant_id = cand[i];
      end
    end
    for (int p = 0; p < P_PORTS; p++) begin
      grant[p] = valid && (grant_id == GRANT_ID_W'(p));
    end
  end

endmodule

// File: rtl/forward_grant_module.sv
// forward_grant_module
// Grant-side responder of the forward request/response handshake. On each
// slot boundary it picks one requesting port round-robin, pulses its grant,
// hands it the slot byte budget, then holds the grant until that port's
// finish line is seen (after a short guard window).
// Optional feature: define FORWARD_GRANT_TIMEOUT_EN to add a wait-for-finish
// limit of P_TIMEOUT cycles that forces release and pulses o_timeout.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_slot_start            one-cycle slot boundary pulse
//   i_slot_bytes[31:0]      slot budget, sampled with i_slot_start
//   i_forward_req[P]        per-port request level
//   o_forward_resp[P]       one-hot grant pulse
//   o_forward_byte[31:0]    latched budget of the current/last grant
//   o_forward_byte_valid[P] one-hot budget strobe
//   i_forward_finish[P]     per-port completion level (high when idle)
//   o_grant_id[2:0]         current or last granted port
//   o_busy                  grant outstanding
//   o_slot_overrun          slot start arrived while busy
//   o_timeout               forced release (always 0 without the macro)
module forward_grant_module
  import forward_grant_pkg::*;
#(
  parameter int P_PORTS = 4,
  parameter int P_GUARD = 2
`ifdef FORWARD_GRANT_TIMEOUT_EN
  ,
  parameter int P_TIMEOUT = 65535
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_slot_start,
  input  logic [31:0]           i_slot_bytes,
  input  logic [P_PORTS-1:0]    i_forward_req,
  output logic [P_PORTS-1:0]    o_forward_resp,
  output logic [31:0]           o_forward_byte,
  output logic [P_PORTS-1:0]    o_forward_byte_valid,
  input  logic [P_PORTS-1:0]    i_forward_finish,
  output logic [GRANT_ID_W-1:0] o_grant_id,
  output logic                  o_busy,
  output logic                  o_slot_overrun,
  output logic                  o_timeout
);

  localparam logic [7:0] GUARD_LAST = 8'(P_GUARD - 1);

  logic [2:0]            state_reg, state_next;
  logic [GRANT_ID_W-1:0] last_reg, last_next;
  logic [GRANT_ID_W-1:0] grant_id_reg, grant_id_next;
  logic [31:0]           byte_reg, byte_next;
  logic [P_PORTS-1:0]    resp_reg, resp_next;
  logic [P_PORTS-1:0]    bval_reg, bval_next;
  logic                  busy_reg, busy_next;
  logic                  overrun_reg, overrun_next;
  logic [7:0]            guard_reg, guard_next;

  logic [P_PORTS-1:0]    arb_grant;
  logic [GRANT_ID_W-1:0] arb_id;
  logic                  arb_valid;
  logic [MAX_PORTS-1:0]  finish_ext;

  assign finish_ext = MAX_PORTS'(i_forward_finish);

`ifdef FORWARD_GRANT_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(P_TIMEOUT - 1);
  logic [15:0] to_cnt_reg, to_cnt_next;
  logic        timeout_reg, timeout_next;
`endif

  rr_arbiter #(
    .P_PORTS (P_PORTS)
  ) u_rr_arbiter (
    .req      (i_forward_req),
    .last     (last_reg),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .valid    (arb_valid)
  );

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    grant_id_next = grant_id_reg;
    byte_next     = byte_reg;
    resp_next     = '0;
    bval_next     = '0;
    guard_next    = guard_reg;
    // A slot boundary outside IDLE is dropped; only flag it.
    overrun_next  = i_slot_start && (state_reg != ST_IDLE);
`ifdef FORWARD_GRANT_TIMEOUT_EN
    to_cnt_next   = to_cnt_reg;
    timeout_next  = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (i_slot_start && arb_valid && (i_slot_bytes != 32'd0)) begin
          state_next    = ST_GRANT;
          byte_next     = i_slot_bytes;
          grant_id_next = arb_id;
          resp_next     = arb_grant;
        end
      end
      ST_GRANT: begin
        // resp_reg still holds the winner's one-hot this cycle.
        state_next = ST_BUDGET;
        bval_next  = resp_reg;
      end
      ST_BUDGET: begin
        guard_next = 8'd0;
        state_next = (P_GUARD == 0) ? ST_WAIT_FIN : ST_GUARD;
`ifdef FORWARD_GRANT_TIMEOUT_EN
        to_cnt_next = 16'd0;
`endif
      end
      ST_GUARD: begin
        // The requester's finish is still its idle-high value until it has
        // latched the budget, so it is not trusted yet.
        if (guard_reg == GUARD_LAST) begin
          state_next = ST_WAIT_FIN;
        end else begin
          guard_next = guard_reg + 8'd1;
        end
      end
      ST_WAIT_FIN: begin
        if (finish_ext[grant_id_reg]) begin
          state_next = ST_IDLE;
          last_next  = grant_id_reg;
        end
`ifdef FORWARD_GRANT_TIMEOUT_EN
        else if (to_cnt_reg == TIMEOUT_LAST) begin
          state_next   = ST_IDLE;
          last_next    = grant_id_reg;
          timeout_next = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + 16'd1;
        end
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      last_reg     <= GRANT_ID_W'(P_PORTS - 1);
      grant_id_reg <= '0;
      byte_reg     <= '0;
      resp_reg     <= '0;
      bval_reg     <= '0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      guard_reg    <= '0;
`ifdef FORWARD_GRANT_TIMEOUT_EN
      to_cnt_reg   <= '0;
      timeout_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      grant_id_reg <= grant_id_next;
      byte_reg     <= byte_next;
      resp_reg     <= resp_next;
      bval_reg     <= bval_next;
      busy_reg     <= busy_next;
      overrun_reg  <= overrun_next;
      guard_reg    <= guard_next;
`ifdef FORWARD_GRANT_TIMEOUT_EN
      to_cnt_reg   <= to_cnt_next;
      timeout_reg  <= timeout_next;
`endif
    end
  end

  assign o_forward_resp       = resp_reg;
  assign o_forward_byte       = byte_reg;
  assign o_forward_byte_valid = bval_reg;
  assign o_grant_id           = grant_id_reg;
  assign o_busy               = busy_reg;
  assign o_slot_overrun       = overrun_reg;
`ifdef FORWARD_GRANT_TIMEOUT_EN
  assign o_timeout            = timeout_reg;
`else
  assign o_timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_forward_grant_module.sv
// tb_forward_grant_module
// Scoreboard bench for forward_grant_module (4 ports, guard 2). Expected
// grants are queued when a slot start is driven and compared when the DUT
// pulses resp / byte_valid. With FORWARD_GRANT_TIMEOUT_EN defined the DUT is
// built with P_TIMEOUT = 100 and the forced-release path is exercised.
module tb_forward_grant_module;
  import forward_grant_pkg::*;

  localparam int NP = 4;

  typedef struct {
    int          port;
    logic [31:0] bytes;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          slot_start;
  logic [31:0]   slot_bytes;
  logic [NP-1:0] req;
  logic [NP-1:0] fin;
  logic [NP-1:0] resp;
  logic [31:0]   fbyte;
  logic [NP-1:0] bval;
  logic [2:0]    grant_id;
  logic          busy;
  logic          overrun;
  logic          timeout;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   bval_pending = 0;
  int   m_last = NP - 1;

  forward_grant_module #(
    .P_PORTS (NP),
    .P_GUARD (2)
`ifdef FORWARD_GRANT_TIMEOUT_EN
    ,
    .P_TIMEOUT (100)
`endif
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_slot_start         (slot_start),
    .i_slot_bytes         (slot_bytes),
    .i_forward_req        (req),
    .o_forward_resp       (resp),
    .o_forward_byte       (fbyte),
    .o_forward_byte_valid (bval),
    .i_forward_finish     (fin),
    .o_grant_id           (grant_id),
    .o_busy               (busy),
    .o_slot_overrun       (overrun),
    .o_timeout            (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot(input int p);
    return 32'(1) << p;
  endfunction

  // Reference round-robin: first requester after `last`, wrapping.
  function automatic int rr_pick(input logic [NP-1:0] r, input int last);
    for (int i = 1; i <= NP; i++) begin
      int p;
      p = (last + i) % NP;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a slot start from IDLE; returns at T+1 after checking the resp pulse.
  task automatic slot_go(input logic [31:0] b);
    int w;
    w = rr_pick(req, m_last);
    if (w >= 0 && b != 32'd0) begin
      exp_q.push_back('{port: w, bytes: b});
      m_last = w;
    end else begin
      w = -1;
    end
    slot_start = 1'b1;
    slot_bytes = b;
    tick();
    slot_start = 1'b0;
    check("resp_t1", 32'(resp), (w >= 0) ? onehot(w) : 32'd0);
    check("busy_t1", 32'(busy), (w >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_release();
    for (int i = 0; i < 60 && busy; i++) tick();
    check("release", 32'(busy), 32'd0);
  endtask

  // Scoreboard side: pop on resp, compare budget strobe one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      bval_pending = 0;
    end else begin
      if (bval_pending) begin
        check("byte_valid", 32'(bval), onehot(cur.port));
        check("byte", fbyte, cur.bytes);
        bval_pending = 0;
      end else if (bval != '0) begin
        check("byte_valid_unexp", 32'(bval), 32'd0);
      end
      if (resp != '0) begin
        if (exp_q.size() == 0) begin
          check("resp_unexp", 32'(resp), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          $display("grant port=%0d bytes=%0d @%0t", cur.port, cur.bytes, $time);
          check("resp", 32'(resp), onehot(cur.port));
          check("grant_id", 32'(grant_id), 32'(cur.port));
          bval_pending = 1;
        end
      end
`ifndef FORWARD_GRANT_TIMEOUT_EN
      if (timeout) check("timeout_tied", 32'(timeout), 32'd0);
`endif
    end
  end

  logic [NP-1:0] pats  [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hA, 4'hA, 4'h9, 4'h9, 4'h1};
  logic [31:0]   budgs [10] = '{DEFAULT_BUDGET, 32'd64, 32'd9000, 32'hFFFF_FFFF, 32'd1,
                                32'd200, 32'd300, 32'd400, 32'd500, 32'd600};

  initial begin
    rst = 1'b1; slot_start = 1'b0; slot_bytes = '0; req = '0; fin = '1;
    tick(); tick(); tick();
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_bval", 32'(bval), 32'd0);
    check("rst_byte", fbyte, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    rst = 1'b0;
    tick();

    // Single requester, then guard / late finish / overrun while busy.
    req = 4'b0100;
    slot_go(32'd3036);                       // now at T+1
    check("t1_grant_id", 32'(grant_id), 32'd2);
    req = '0;                                // withdrawal must not cancel
    tick();                                  // T+2
    check("t2_bval", 32'(bval), 32'h4);
    check("t2_byte", fbyte, 32'd3036);
    tick(); tick(); tick();                  // T+5: finish was high through guard
    fin[2] = 1'b0;
    check("guard_busy", 32'(busy), 32'd1);
    for (int c = 6; c <= 50; c++) begin
      tick();
      check("wait_busy", 32'(busy), 32'd1);
      if (c == 20) begin
        slot_start = 1'b1; slot_bytes = 32'd999; req = 4'b0001;
      end
      if (c == 21) begin
        slot_start = 1'b0; req = '0;
        check("overrun_pulse", 32'(overrun), 32'd1);
      end
      if (c == 22) begin
        check("overrun_clear", 32'(overrun), 32'd0);
        check("budget_kept", fbyte, 32'd3036);
      end
      if (c == 50) fin[2] = 1'b1;
    end
    tick();                                  // T+51
    check("release_t51", 32'(busy), 32'd0);

    // Skipped slots: no requests, then zero budget.
    req = '0;
    slot_go(32'd100);
    req = 4'hF;
    slot_go(32'd0);
    check("skip_overrun", 32'(overrun), 32'd0);

    // Reset in the middle of a grant; pointer returns to port 0 first.
    req = 4'b0001; fin = '0;
    slot_go(32'd777);                        // winner 0
    tick(); tick(); tick();                  // T+4
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_last = NP - 1;
    fin = '1;
    tick();

    // Round-robin order over a table of request patterns.
    for (int k = 0; k < 10; k++) begin
      req = pats[k];
      slot_go(budgs[k]);
      wait_release();                        // next slot driven at F+1
    end

`ifdef FORWARD_GRANT_TIMEOUT_EN
    req = 4'hF; fin = '0;
    slot_go(32'd500);                        // T+1, winner 1
    for (int c = 2; c <= 104; c++) begin
      tick();
      if (timeout) check("timeout_early", 32'(timeout), 32'd0);
    end
    tick();                                  // T+105
    check("timeout_pulse", 32'(timeout), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    tick();
    check("timeout_clear", 32'(timeout), 32'd0);
    fin = '1;
    slot_go(32'd42);                         // next in order: port 2
    check("after_timeout_id", 32'(grant_id), 32'd2);
    wait_release();
`endif

    tick(); tick(); tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("bval_pending", 32'(bval_pending), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
